// File: rtl/vga_timing.sv
// VGA timing generator: h/v counters, FIFO start/pop control and registered sync/blank/RGB outputs.
// Defining VGA_TIMING_TESTPATTERN_EN adds a test_en input that replaces the FIFO stream with colour bars.
module vga_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_rempty,
  input  logic        fifo_ready,
`ifdef VGA_TIMING_TESTPATTERN_EN
  input  logic        test_en,
`endif
  output logic        fifo_read,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        underflow
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;

  typedef enum logic [1:0] {
    WAIT_FILL  = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic          underflow_q, underflow_d;
  logic [23:0]   rgb_q, rgb_d;

  logic h_sync, v_sync, h_vis, v_vis, active, test_mode;
  logic unused_rdata;

  assign unused_rdata = ^fifo_rdata[31:24];

`ifdef VGA_TIMING_TESTPATTERN_EN
  assign test_mode = test_en;
`else
  assign test_mode = 1'b0;
`endif

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(HTOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(VTOTAL - 1)) ? '0 : vcnt_q + VW'(1);
    end
  end

  // Each axis runs front porch, sync, back porch, then visible.
  always_comb begin
    h_sync = (hcnt_q >= HW'(HFP)) && (hcnt_q < HW'(HFP + HPULSE));
    v_sync = (vcnt_q >= VW'(VFP)) && (vcnt_q < VW'(VFP + VPULSE));
    h_vis  = (hcnt_q >= HW'(HSTART));
    v_vis  = (vcnt_q >= VW'(VSTART));
    active = h_vis && v_vis;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FILL:  if (fifo_ready) state_d = WAIT_FRAME;
      WAIT_FRAME: if ((hcnt_q == '0) && (vcnt_q == '0)) state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_FILL;
    endcase
  end

`ifdef VGA_TIMING_TESTPATTERN_EN
  logic [HW-1:0] bar_pix;
  logic [HW+2:0] bar_scaled;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb;
  logic          unused_bar;

  // Bar index = offset*8/HDISP; bits of the index select R, G, B at full scale.
  always_comb begin
    bar_pix    = hcnt_q - HW'(HSTART);
    bar_scaled = {bar_pix, 3'b000} / (HW+3)'(HDISP);
    bar_idx    = bar_scaled[2:0];
    bar_rgb    = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
  end

  assign unused_bar = ^bar_scaled[HW+2:3];
`endif

  always_comb begin
    fifo_read   = (state_q == RUN) && active && !fifo_rempty && !test_mode;
    underflow_d = underflow_q;
    if ((state_q == RUN) && active && fifo_rempty && !test_mode) underflow_d = 1'b1;
    rgb_d = '0;
    if (fifo_read) rgb_d = fifo_rdata[23:0];
`ifdef VGA_TIMING_TESTPATTERN_EN
    if (test_mode && active) rgb_d = bar_rgb;
`endif
    hs_d    = !h_sync;
    vs_d    = !v_sync;
    blank_d = active;
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state_q     <= WAIT_FILL;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign VGA_BLANK = blank_q;
  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];
  assign underflow = underflow_q;

endmodule
